// File: rtl/sift_out_adder.sv
// Fault-tolerant adder: three ripple-carry replicas, a pairwise comparator network and a
// sticky exclusion register. Optional macro SIFT_FAULT_INJECT_EN adds inj/excluded ports.
module sift_out_adder #(
    parameter int unsigned adder_width = 32
) (
    input  logic                   clk,
    input  logic                   K,
    input  logic [adder_width-1:0] in1,
    input  logic [adder_width-1:0] in2,
    input  logic                   cin,
`ifdef SIFT_FAULT_INJECT_EN
    input  logic [2:0]             inj,
    output logic [2:0]             excluded,
`endif
    output logic [adder_width-1:0] sum,
    output logic                   cout
);

    localparam int unsigned RW = adder_width + 1;
    localparam int unsigned NR = 3;

    logic [adder_width:0]   carry [NR];
    logic [adder_width-1:0] s_raw [NR];
    logic [RW-1:0]          res   [NR];
    logic [NR-1:0]          inj_w;
    logic                   m01, m02, m12;
    logic [NR-1:0]          ex_d, ex_q;
    logic [RW-1:0]          out_c;

`ifdef SIFT_FAULT_INJECT_EN
    assign inj_w    = inj;
    assign excluded = ex_q;
`else
    assign inj_w    = '0;
`endif

    // Three independent ripple-carry chains; injection flips sum bit 0 of a replica.
    for (genvar r = 0; r < NR; r++) begin : g_rep
        assign carry[r][0] = cin;
        for (genvar b = 0; b < adder_width; b++) begin : g_bit
            assign s_raw[r][b]   = in1[b] ^ in2[b] ^ carry[r][b];
            assign carry[r][b+1] = (in1[b] & in2[b]) | (carry[r][b] & (in1[b] ^ in2[b]));
        end
        assign res[r] = {carry[r][adder_width], s_raw[r] ^ adder_width'(inj_w[r])};
    end

    assign m01 = (res[0] == res[1]);
    assign m02 = (res[0] == res[2]);
    assign m12 = (res[1] == res[2]);

    // A replica is sifted out only when all three are active and it alone is the outlier.
    always_comb begin
        ex_d = ex_q;
        if (ex_q == 3'b000) begin
            if (m12 && !m01 && !m02) begin
                ex_d[0] = 1'b1;
            end else if (m02 && !m01 && !m12) begin
                ex_d[1] = 1'b1;
            end else if (m01 && !m02 && !m12) begin
                ex_d[2] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge K) begin
        if (K) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Collector: majority vote when nothing excluded, else lowest-index survivor.
    always_comb begin
        out_c = res[0];
        case (ex_q)
            3'b000:  out_c = (res[0] & res[1]) | (res[0] & res[2]) | (res[1] & res[2]);
            3'b001:  out_c = res[1];
            3'b010:  out_c = res[0];
            3'b100:  out_c = res[0];
            3'b011:  out_c = res[2];
            3'b101:  out_c = res[1];
            3'b110:  out_c = res[0];
            default: out_c = res[0];
        endcase
    end

    assign sum  = out_c[adder_width-1:0];
    assign cout = out_c[adder_width];

endmodule

// File: tb/tb_sift_out_adder.sv
// Directed, table-driven bench for sift_out_adder; fault-injection sequences run only
// when SIFT_FAULT_INJECT_EN is defined.
module tb_sift_out_adder;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         K;
    logic [W-1:0] in1, in2, sum;
    logic         cin, cout;
    logic [2:0]   ex_obs;
`ifdef SIFT_FAULT_INJECT_EN
    logic [2:0]   inj;
    logic [2:0]   excluded;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sift_out_adder #(.adder_width(W)) dut (
        .clk (clk),
        .K   (K),
        .in1 (in1),
        .in2 (in2),
        .cin (cin),
`ifdef SIFT_FAULT_INJECT_EN
        .inj      (inj),
        .excluded (excluded),
`endif
        .sum (sum),
        .cout(cout)
    );

`ifdef SIFT_FAULT_INJECT_EN
    assign ex_obs = excluded;
`else
    assign ex_obs = dut.ex_q;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [W-1:0] es, input logic ec);
        check({name, ".sum"}, 64'(sum), 64'(es));
        check({name, ".cout"}, 64'(cout), 64'(ec));
    endtask

    initial begin
        vecs[0]  = '{a: 32'd1, b: 32'd1, ci: 1'b1, exp_sum: 32'd3, exp_cout: 1'b0};
        vecs[1]  = '{a: 32'd2, b: 32'd2, ci: 1'b0, exp_sum: 32'd4, exp_cout: 1'b0};
        vecs[2]  = '{a: 32'd4, b: 32'd4, ci: 1'b0, exp_sum: 32'd8, exp_cout: 1'b0};
        vecs[3]  = '{a: 32'd8, b: 32'd8, ci: 1'b0, exp_sum: 32'd16, exp_cout: 1'b0};
        vecs[4]  = '{a: 32'd16, b: 32'd16, ci: 1'b0, exp_sum: 32'd32, exp_cout: 1'b0};
        vecs[5]  = '{a: 32'd32, b: 32'd32, ci: 1'b0, exp_sum: 32'd64, exp_cout: 1'b0};
        vecs[6]  = '{a: 32'd64, b: 32'd64, ci: 1'b0, exp_sum: 32'd128, exp_cout: 1'b0};
        vecs[7]  = '{a: 32'hFFFF_FFFF, b: 32'd1, ci: 1'b0, exp_sum: 32'd0, exp_cout: 1'b1};
        vecs[8]  = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, ci: 1'b1, exp_sum: 32'hFFFF_FFFF, exp_cout: 1'b1};
        vecs[9]  = '{a: 32'h1234_5678, b: 32'h0F0F_0F0F, ci: 1'b0, exp_sum: 32'h2143_6587, exp_cout: 1'b0};
        vecs[10] = '{a: 32'h8000_0000, b: 32'h8000_0000, ci: 1'b1, exp_sum: 32'd1, exp_cout: 1'b1};

        K = 1'b1; in1 = '0; in2 = '0; cin = 1'b0;
`ifdef SIFT_FAULT_INJECT_EN
        inj = 3'b000;
`endif
        #23;
        check_out("reset", 32'd0, 1'b0);
        check("reset.ex", 64'(ex_obs), 64'd0);
        @(negedge clk);
        K = 1'b0;
        @(negedge clk);
        check_out("post_reset", 32'd0, 1'b0);
        check("post_reset.ex", 64'(ex_obs), 64'd0);

        for (int i = 0; i < 11; i++) begin
            in1 = vecs[i].a; in2 = vecs[i].b; cin = vecs[i].ci;
            #50;
            check_out($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout);
            check($sformatf("vec%0d.ex", i), 64'(ex_obs), 64'd0);
            #50;
        end

`ifdef SIFT_FAULT_INJECT_EN
        // Replica 1 faulty: masked immediately, sifted out on the next edge.
        in1 = 32'd1; in2 = 32'd1; cin = 1'b0; inj = 3'b010;
        #2;
        check_out("mask_before_edge", 32'd2, 1'b0);
        check("mask_before_edge.ex", 64'(ex_obs), 64'd0);
        @(posedge clk); #1;
        check("excl1", 64'(ex_obs), 64'b010);
        check_out("excl1", 32'd2, 1'b0);
        @(negedge clk);
        inj = 3'b000;
        #2;
        check("inj_clear.ex", 64'(ex_obs), 64'b010);
        check_out("inj_clear", 32'd2, 1'b0);

        // Two survivors disagree: undecidable, output follows replica 0.
        @(negedge clk);
        inj = 3'b001;
        #2;
        check_out("two_dis_pre", 32'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("two_dis.ex", 64'(ex_obs), 64'b010);
        check_out("two_dis", 32'd3, 1'b0);

        // Asynchronous K between edges clears at once; majority vote returns.
        #2;
        K = 1'b1;
        #1;
        check("async_k.ex", 64'(ex_obs), 64'd0);
        check_out("async_k", 32'd2, 1'b0);
        @(posedge clk); #1;
        check("k_held.ex", 64'(ex_obs), 64'd0);
        @(negedge clk);
        K = 1'b0;
        @(posedge clk); #1;
        check("excl0.ex", 64'(ex_obs), 64'b001);
        check_out("excl0", 32'd2, 1'b0);

        // Only replicas 1 and 2 active and disagreeing: no change, lowest active wins.
        @(negedge clk);
        inj = 3'b010;
        @(posedge clk); #1;
        check("excl0_dis.ex", 64'(ex_obs), 64'b001);
        check_out("excl0_dis", 32'd3, 1'b0);
        @(negedge clk);
        inj = 3'b000;
        K = 1'b1;
        #2;
        K = 1'b0;
        check("final_clear.ex", 64'(ex_obs), 64'd0);
`else
        // Reset mid-operation leaves the arithmetic untouched.
        in1 = 32'd1; in2 = 32'd1; cin = 1'b0;
        @(posedge clk); #3;
        K = 1'b1;
        #1;
        check_out("k_mid", 32'd2, 1'b0);
        check("k_mid.ex", 64'(ex_obs), 64'd0);
        @(negedge clk);
        K = 1'b0;
        @(posedge clk); #1;
        check_out("k_release", 32'd2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
